// File: rtl/thermometer_stream_checker.sv
// Two-stage valid/ready thermometer-code checker and decoder.
// Classifies each word as LSB- or MSB-aligned, decodes the level and counts bad words.
module thermometer_stream_checker #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16,
   parameter int BUBBLE_FIX = 0,
   localparam int LW = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  resetn_i,
   input  logic [1:0]            mode_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] code_in_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  is_therm_o,
   output logic                  dir_o,
   output logic [LW-1:0]         level_o,
   output logic                  bubble_fixed_o,
   output logic [CNT_WIDTH-1:0]  err_count_o,
   input  logic                  clr_count_i
);

   localparam int DW = DATA_WIDTH;

   // (1<<k)-1 patterns are exactly those where w and w+1 share no set bit
   function automatic logic lsb_legal(input logic [DW-1:0] w);
      return ((w & (w + DW'(1))) == '0);
   endfunction

   function automatic logic [DW-1:0] bit_rev(input logic [DW-1:0] w);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
      return r;
   endfunction

   function automatic logic [DW-1:0] maj_fix(input logic [DW-1:0] w,
                                             input logic lo_pad, input logic hi_pad);
      logic [DW+1:0] e;
      logic [DW-1:0] c;
      e = {hi_pad, w, lo_pad};
      c = '0;
      for (int i = 0; i < DW; i++)
         c[i] = (e[i] & e[i+1]) | (e[i] & e[i+2]) | (e[i+1] & e[i+2]);
      return c;
   endfunction

   function automatic logic [LW-1:0] popcnt(input logic [DW-1:0] w);
      logic [LW-1:0] n;
      n = '0;
      for (int i = 0; i < DW; i++) n = n + LW'(w[i]);
      return n;
   endfunction

   logic                 s1_v_q, s1_v_d;
   logic [DW-1:0]        s1_code_q, s1_code_d;
   logic [1:0]           s1_mode_q, s1_mode_d;
   logic                 s2_v_q, s2_v_d;
   logic                 therm_q, therm_d;
   logic                 dir_q, dir_d;
   logic [LW-1:0]        level_q, level_d;
   logic                 bfix_q, bfix_d;
   logic [CNT_WIDTH-1:0] err_q, err_d;

   logic          s1_adv, s2_adv;
   logic [DW-1:0] w_lsb, w_msb, match;
   logic          lsb_ok, msb_ok;

   assign s2_adv     = !s2_v_q | out_ready_i;
   assign s1_adv     = !s1_v_q | s2_adv;
   assign in_ready_o = s1_adv;

   // Each alignment gets its own correction, padded toward its own fill side
   assign w_lsb  = (BUBBLE_FIX != 0) ? maj_fix(s1_code_q, 1'b1, 1'b0) : s1_code_q;
   assign w_msb  = (BUBBLE_FIX != 0) ? maj_fix(s1_code_q, 1'b0, 1'b1) : s1_code_q;
   assign lsb_ok = lsb_legal(w_lsb);
   assign msb_ok = lsb_legal(bit_rev(w_msb));

   always_comb begin
      therm_d = 1'b0;
      dir_d   = 1'b0;
      match   = s1_code_q;
      case (s1_mode_q)
         2'b00: begin
            therm_d = lsb_ok;
            match   = w_lsb;
         end
         2'b01: begin
            therm_d = msb_ok;
            dir_d   = msb_ok;
            match   = w_msb;
         end
         default: begin
            if (lsb_ok) begin
               therm_d = 1'b1;
               match   = w_lsb;
            end else if (msb_ok) begin
               therm_d = 1'b1;
               dir_d   = 1'b1;
               match   = w_msb;
            end
         end
      endcase
      level_d = therm_d ? popcnt(match) : '0;
      bfix_d  = (BUBBLE_FIX != 0) && therm_d && (match != s1_code_q);
   end

   always_comb begin
      s1_v_d    = s1_adv ? in_valid_i : s1_v_q;
      s1_code_d = s1_code_q;
      s1_mode_d = s1_mode_q;
      if (s1_adv && in_valid_i) begin
         s1_code_d = code_in_i;
         s1_mode_d = mode_i;
      end
      s2_v_d = s2_adv ? s1_v_q : s2_v_q;
   end

   // Clear wins over a same-cycle increment; increment stops at all-ones
   always_comb begin
      err_d = err_q;
      if (clr_count_i)
         err_d = '0;
      else if (s2_v_q && out_ready_i && !therm_q && !(&err_q))
         err_d = err_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         s1_v_q    <= 1'b0;
         s1_code_q <= '0;
         s1_mode_q <= '0;
         s2_v_q    <= 1'b0;
         therm_q   <= 1'b0;
         dir_q     <= 1'b0;
         level_q   <= '0;
         bfix_q    <= 1'b0;
         err_q     <= '0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_code_q <= s1_code_d;
         s1_mode_q <= s1_mode_d;
         s2_v_q    <= s2_v_d;
         err_q     <= err_d;
         if (s2_adv && s1_v_q) begin
            therm_q <= therm_d;
            dir_q   <= dir_d;
            level_q <= level_d;
            bfix_q  <= bfix_d;
         end
      end
   end

   assign out_valid_o    = s2_v_q;
   assign is_therm_o     = therm_q;
   assign dir_o          = dir_q;
   assign level_o        = level_q;
   assign bubble_fixed_o = bfix_q;
   assign err_count_o    = err_q;

endmodule
